// File: rtl/fb_pkg.sv
// Shared defaults, state encodings and sizing helper for the ping-pong frame buffer.
package fb_pkg;

  localparam int unsigned FB_FRAME_WIDTH  = 640;
  localparam int unsigned FB_FRAME_HEIGHT = 480;
  localparam int unsigned FB_PIXEL_W      = 3;

  typedef enum logic {
    SWP_IDLE,
    SWP_PENDING
  } swp_state_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  // Bank address width for a w x h frame; never narrower than one bit.
  function automatic int unsigned fb_addr_w(input int unsigned w, input int unsigned h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One pixel bank: simple dual-port synchronous RAM, one write port, one registered read port.
module frame_bank #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PIXEL_W = 3,
  parameter int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PIXEL_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: draw side fills the back bank, display reads the front bank,
// swaps land only on display end-of-frame, and a clear engine can flood the back bank.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int unsigned       FRAME_WIDTH  = FB_FRAME_WIDTH,
  parameter int unsigned       FRAME_HEIGHT = FB_FRAME_HEIGHT,
  parameter int unsigned       PIXEL_W      = FB_PIXEL_W,
  parameter logic [PIXEL_W-1:0] CLEAR_VALUE = '0,
  parameter int unsigned       X_W          = $clog2(FRAME_WIDTH),
  parameter int unsigned       Y_W          = $clog2(FRAME_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W-1:0]     write_x,
  input  logic [Y_W-1:0]     write_y,
  input  logic               write_enable,
  input  logic [PIXEL_W-1:0] write_data,
  output logic               write_ready,
  input  logic [X_W-1:0]     read_x,
  input  logic [Y_W-1:0]     read_y,
  input  logic               read_enable,
  output logic [PIXEL_W-1:0] read_data,
  output logic               read_valid,
  input  logic               swap_req,
  input  logic               frame_done,
  output logic               swap_ack,
  output logic               front_sel,
  input  logic               clear_req,
  output logic               clear_busy
);

  localparam int unsigned DEPTH  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned ADDR_W = fb_addr_w(FRAME_WIDTH, FRAME_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  swp_state_e          swap_state_q, swap_state_d;
  logic                swap_latched_q, swap_latched_d;
  logic                front_sel_q, front_sel_d;
  logic                swap_ack_q, swap_ack_d;
  clr_state_e          clr_state_q, clr_state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_sel_q, rd_sel_d;
  logic                rd_zero_q, rd_zero_d;

  logic                clr_busy;
  logic                clr_we;
  logic                swap_pending;
  logic                draw_we;
  logic [31:0]         wr_lin, rd_lin;
  logic                wr_in_range, rd_in_range;
  logic                bank_we;
  logic [ADDR_W-1:0]   bank_waddr;
  logic [PIXEL_W-1:0]  bank_wdata;
  logic [PIXEL_W-1:0]  bank0_rdata, bank1_rdata;

  assign clr_busy     = (clr_state_q == CLR_RUN);
  assign swap_pending = (swap_state_q == SWP_PENDING) || swap_latched_q;
  assign write_ready  = !clr_busy && !swap_pending;

  // Linear address at 32 bits; with x in range, lin < DEPTH is equivalent to y in range.
  always_comb begin
    wr_lin      = 32'(write_y) * FRAME_WIDTH + 32'(write_x);
    rd_lin      = 32'(read_y) * FRAME_WIDTH + 32'(read_x);
    wr_in_range = (32'(write_x) < FRAME_WIDTH) && (wr_lin < DEPTH);
    rd_in_range = (32'(read_x) < FRAME_WIDTH) && (rd_lin < DEPTH);
  end

  // Swap sequencing; a request during a clear is parked until the clear has finished.
  always_comb begin
    swap_state_d   = swap_state_q;
    swap_latched_d = swap_latched_q;
    front_sel_d    = front_sel_q;
    swap_ack_d     = 1'b0;
    unique case (swap_state_q)
      SWP_IDLE: begin
        if (swap_latched_q) begin
          if (!clr_busy) begin
            swap_latched_d = 1'b0;
            swap_state_d   = SWP_PENDING;
          end
        end else if (swap_req) begin
          if (clr_busy) begin
            swap_latched_d = 1'b1;
          end else if (frame_done) begin
            front_sel_d = !front_sel_q;
            swap_ack_d  = 1'b1;
          end else begin
            swap_state_d = SWP_PENDING;
          end
        end
      end
      SWP_PENDING: begin
        if (frame_done && !clr_busy) begin
          front_sel_d  = !front_sel_q;
          swap_ack_d   = 1'b1;
          swap_state_d = SWP_IDLE;
        end
      end
      default: swap_state_d = SWP_IDLE;
    endcase
  end

  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_we      = 1'b0;
    unique case (clr_state_q)
      CLR_IDLE: begin
        if (clear_req && (swap_state_q == SWP_IDLE) && !swap_latched_q) begin
          clr_state_d = CLR_RUN;
          clr_cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d   = '0;
          clr_state_d = CLR_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: clr_state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    draw_we    = write_enable && write_ready && wr_in_range;
    bank_we    = rst_n && (clr_we || draw_we);
    bank_waddr = clr_we ? clr_cnt_q : wr_lin[ADDR_W-1:0];
    bank_wdata = clr_we ? CLEAR_VALUE : write_data;
    rd_valid_d = read_enable;
    rd_sel_d   = read_enable ? front_sel_q : rd_sel_q;
    rd_zero_d  = read_enable ? !rd_in_range : rd_zero_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_state_q   <= SWP_IDLE;
      swap_latched_q <= 1'b0;
      front_sel_q    <= 1'b0;
      swap_ack_q     <= 1'b0;
      clr_state_q    <= CLR_IDLE;
      clr_cnt_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_sel_q       <= 1'b0;
      rd_zero_q      <= 1'b1;
    end else begin
      swap_state_q   <= swap_state_d;
      swap_latched_q <= swap_latched_d;
      front_sel_q    <= front_sel_d;
      swap_ack_q     <= swap_ack_d;
      clr_state_q    <= clr_state_d;
      clr_cnt_q      <= clr_cnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_sel_q       <= rd_sel_d;
      rd_zero_q      <= rd_zero_d;
    end
  end

  frame_bank #(
    .DEPTH  (DEPTH),
    .PIXEL_W(PIXEL_W),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk    (clk),
    .wr_en  (bank_we && front_sel_q),
    .wr_addr(bank_waddr),
    .wr_data(bank_wdata),
    .rd_en  (read_enable && rd_in_range && !front_sel_q),
    .rd_addr(rd_lin[ADDR_W-1:0]),
    .rd_data(bank0_rdata)
  );

  frame_bank #(
    .DEPTH  (DEPTH),
    .PIXEL_W(PIXEL_W),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk    (clk),
    .wr_en  (bank_we && !front_sel_q),
    .wr_addr(bank_waddr),
    .wr_data(bank_wdata),
    .rd_en  (read_enable && rd_in_range && front_sel_q),
    .rd_addr(rd_lin[ADDR_W-1:0]),
    .rd_data(bank1_rdata)
  );

  assign read_data  = rd_zero_q ? '0 : (rd_sel_q ? bank1_rdata : bank0_rdata);
  assign read_valid = rd_valid_q;
  assign swap_ack   = swap_ack_q;
  assign front_sel  = front_sel_q;
  assign clear_busy = clr_busy;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Scoreboard bench: an 8x4 instance against a behavioural frame model, plus a default 640x480 instance.
module tb_frame_buffer_pingpong;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int PW = 3;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam logic [PW-1:0] CV = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [XW-1:0] write_x = '0;
  logic [YW-1:0] write_y = '0;
  logic          write_enable = 1'b0;
  logic [PW-1:0] write_data = '0;
  logic          write_ready;
  logic [XW-1:0] read_x = '0;
  logic [YW-1:0] read_y = '0;
  logic          read_enable = 1'b0;
  logic [PW-1:0] read_data;
  logic          read_valid;
  logic          swap_req = 1'b0, frame_done = 1'b0, clear_req = 1'b0;
  logic          swap_ack, front_sel, clear_busy;

  frame_buffer_pingpong #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .PIXEL_W     (PW),
    .CLEAR_VALUE (CV),
    .X_W         (XW),
    .Y_W         (YW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_x(write_x), .write_y(write_y), .write_enable(write_enable),
    .write_data(write_data), .write_ready(write_ready),
    .read_x(read_x), .read_y(read_y), .read_enable(read_enable),
    .read_data(read_data), .read_valid(read_valid),
    .swap_req(swap_req), .frame_done(frame_done), .swap_ack(swap_ack),
    .front_sel(front_sel), .clear_req(clear_req), .clear_busy(clear_busy)
  );

  // Default-size instance
  logic       d2_rst_n = 1'b0;
  logic [9:0] d2_wx = '0, d2_rx = '0;
  logic [8:0] d2_wy = '0, d2_ry = '0;
  logic       d2_we = 1'b0, d2_re = 1'b0;
  logic [2:0] d2_wd = '0;
  logic       d2_wready, d2_rvalid;
  logic [2:0] d2_rdata;
  logic       d2_swap_req = 1'b0, d2_frame_done = 1'b0, d2_clear_req = 1'b0;
  logic       d2_swap_ack, d2_front_sel, d2_clear_busy;

  frame_buffer_pingpong dut_full (
    .clk(clk), .rst_n(d2_rst_n),
    .write_x(d2_wx), .write_y(d2_wy), .write_enable(d2_we),
    .write_data(d2_wd), .write_ready(d2_wready),
    .read_x(d2_rx), .read_y(d2_ry), .read_enable(d2_re),
    .read_data(d2_rdata), .read_valid(d2_rvalid),
    .swap_req(d2_swap_req), .frame_done(d2_frame_done), .swap_ack(d2_swap_ack),
    .front_sel(d2_front_sel), .clear_req(d2_clear_req), .clear_busy(d2_clear_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [PW-1:0] data;
    int            cyc;
  } rd_t;

  rd_t           sb[$];
  logic [PW-1:0] ref_mem [2][N];
  bit            m_front, m_pend, m_parked, m_ack, model_ok;
  int            m_clear_left;
  int            cyc = 0;
  bit            m_busy, m_ready;
  logic [PW-1:0] last_rd = '0;

  function automatic logic [PW-1:0] ref_pix(input int x, input int y, input bit bank);
    if (x >= W || y >= H) return '0;
    return ref_mem[bank][y * W + x];
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_front = 0; m_pend = 0; m_parked = 0; m_ack = 0; m_clear_left = 0;
      sb.delete();
      last_rd  = '0;
      model_ok = 1;
    end else if (model_ok) begin
      m_busy  = m_clear_left > 0;
      m_ready = !m_busy && !m_pend && !m_parked;
      m_ack   = 0;
      if (read_enable)
        sb.push_back('{ref_pix(int'(read_x), int'(read_y), m_front), cyc});
      if (write_enable && m_ready && int'(write_x) < W && int'(write_y) < H)
        ref_mem[!m_front][int'(write_y) * W + int'(write_x)] = write_data;
      if (m_busy) begin
        ref_mem[!m_front][N - m_clear_left] = CV;
        m_clear_left--;
      end else if (clear_req && !m_pend && !m_parked) begin
        m_clear_left = N;
      end
      // A swap needs an end-of-frame seen while no clear runs; requests during a clear wait for it.
      if (m_pend) begin
        if (frame_done && !m_busy) begin
          m_front = !m_front; m_ack = 1; m_pend = 0;
        end
      end else if (m_parked) begin
        if (!m_busy) begin
          m_parked = 0; m_pend = 1;
        end
      end else if (swap_req) begin
        if (m_busy) m_parked = 1;
        else if (frame_done) begin
          m_front = !m_front; m_ack = 1;
        end else m_pend = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      rd_t e;
      chk("swap_ack", swap_ack, m_ack);
      chk("front_sel", front_sel, m_front);
      chk("clear_busy", clear_busy, m_clear_left > 0);
      chk("write_ready", write_ready, !(m_clear_left > 0) && !m_pend && !m_parked);
      if (read_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", read_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("rd_latency", cyc, e.cyc);
          chk("rd_data", read_data, e.data);
          last_rd = e.data;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc == cyc) chk("rd_missing", read_valid, 1);
        chk("rd_hold", read_data, last_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    write_enable = 0; read_enable = 0; swap_req = 0; frame_done = 0; clear_req = 0;
    d2_we = 0; d2_re = 0; d2_swap_req = 0; d2_frame_done = 0; d2_clear_req = 0;
  endtask

  task automatic wr(input int x, input int y, input int d);
    write_x = XW'(x); write_y = YW'(y); write_data = PW'(d); write_enable = 1;
    tick();
  endtask

  task automatic rd(input int x, input int y);
    read_x = XW'(x); read_y = YW'(y); read_enable = 1;
    tick();
  endtask

  task automatic read_all();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd(x, y);
    tick(); tick();
  endtask

  int n;
  int fx[8] = '{0, 639, 639, 0, 320, 1, 100, 638};
  int fy[8] = '{0, 479, 0, 479, 240, 1, 200, 479};
  logic [2:0] fd[8];

  initial begin
    repeat (3) tick();
    chk("rst_front_sel", front_sel, 0);
    chk("rst_write_ready", write_ready, 1);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    rst_n = 1;
    tick();

    // 1: pattern into back bank, swap on end-of-frame, read everything back
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) wr(x, y, (x + y) % 8);
    swap_req = 1; tick();
    frame_done = 1; tick();
    chk("s1_ack", swap_ack, 1);
    chk("s1_front", front_sel, 1);
    tick();
    read_all();

    // 3: clear the back bank, length of clear_busy, then show it
    clear_req = 1; tick();
    n = 0;
    repeat (40) begin
      if (clear_busy) n++;
      tick();
    end
    chk("s3_clear_len", n, N);
    swap_req = 1; frame_done = 1; tick();
    tick();
    read_all();

    // 2: writes refused while a swap waits; duplicate request gives one ack
    swap_req = 1; tick();
    tick(); tick();
    chk("s2_ready_low", write_ready, 0);
    wr(1, 1, 7);
    swap_req = 1; tick();
    repeat (8) tick();
    frame_done = 1; tick();
    n = 0;
    repeat (6) begin
      if (swap_ack) n++;
      tick();
    end
    chk("s2_one_ack", n, 1);
    rd(1, 1);
    tick();
    read_all();

    // 4: swap requested and end-of-frame during a clear
    for (int i = 0; i < N; i++) wr(i % W, i / W, $urandom_range(0, 7));
    clear_req = 1; tick();
    repeat (5) tick();
    swap_req = 1; tick();
    repeat (5) tick();
    frame_done = 1; tick();
    repeat (30) tick();
    frame_done = 1; tick();
    chk("s4_ack", swap_ack, 1);
    tick();
    read_all();

    // 5: out-of-range access
    rd(8, 0); rd(0, 4); rd(15, 7);
    wr(9, 0, 3); wr(0, 5, 3);
    swap_req = 1; frame_done = 1; tick();
    read_all();

    // 6: reset in the middle of a clear
    clear_req = 1; tick();
    repeat (10) tick();
    rst_n = 0; tick();
    chk("s6_busy", clear_busy, 0);
    chk("s6_front", front_sel, 0);
    chk("s6_ready", write_ready, 1);
    rst_n = 1; tick();
    swap_req = 1; frame_done = 1; tick();
    read_all();

    // random traffic
    repeat (600) begin
      write_enable = ($urandom_range(0, 1) == 1);
      write_x = XW'($urandom_range(0, 9));
      write_y = YW'($urandom_range(0, 4));
      write_data = PW'($urandom);
      read_enable = ($urandom_range(0, 1) == 1);
      read_x = XW'($urandom_range(0, 9));
      read_y = YW'($urandom_range(0, 4));
      swap_req = ($urandom_range(0, 19) == 0);
      frame_done = ($urandom_range(0, 14) == 0);
      clear_req = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      rst_n = 1;
    end
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);

    // default 640x480 instance: corners and interior, same-cycle swap
    tick();
    d2_rst_n = 1; tick();
    chk("d2_rst_ready", d2_wready, 1);
    for (int i = 0; i < 8; i++) begin
      fd[i] = 3'($urandom);
      d2_wx = 10'(fx[i]); d2_wy = 9'(fy[i]); d2_wd = fd[i]; d2_we = 1;
      tick();
    end
    d2_swap_req = 1; d2_frame_done = 1; tick();
    chk("d2_ack", d2_swap_ack, 1);
    chk("d2_front", d2_front_sel, 1);
    for (int i = 0; i < 8; i++) begin
      d2_rx = 10'(fx[i]); d2_ry = 9'(fy[i]); d2_re = 1;
      tick();
      chk("d2_rvalid", d2_rvalid, 1);
      chk("d2_rdata", d2_rdata, fd[i]);
    end
    d2_rx = 10'd640; d2_ry = 9'd0; d2_re = 1;
    tick();
    chk("d2_oor_valid", d2_rvalid, 1);
    chk("d2_oor_data", d2_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
